// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
// Core-side bus of mem_arbiter: the instruction-fetch req/ack port and the
// pipelined Wishbone data port. The core drives the master view and the
// arbiter takes the slave view.
interface mem_arbiter_if;
    // Instruction fetch port
    logic [31:0] main_memory_instr_addr;
    logic        main_memory_instr_req;
    logic [31:0] main_memory_instr;
    logic        main_memory_instr_ack;

    // Pipelined Wishbone data port
    logic        main_memory_wb_cyc;
    logic        main_memory_wb_stb;
    logic        main_memory_wb_wr_en;
    logic [31:0] main_memory_wb_addr;
    logic [31:0] main_memory_wb_wr_data;
    logic [3:0]  main_memory_wb_wr_sel;
    logic        main_memory_wb_ack;
    logic        main_memory_wb_stall;
    logic [31:0] main_memory_wb_rd_data;

    modport master (
        output main_memory_instr_addr, main_memory_instr_req,
        input  main_memory_instr, main_memory_instr_ack,
        output main_memory_wb_cyc, main_memory_wb_stb, main_memory_wb_wr_en,
        output main_memory_wb_addr, main_memory_wb_wr_data, main_memory_wb_wr_sel,
        input  main_memory_wb_ack, main_memory_wb_stall, main_memory_wb_rd_data
    );

    modport slave (
        input  main_memory_instr_addr, main_memory_instr_req,
        output main_memory_instr, main_memory_instr_ack,
        input  main_memory_wb_cyc, main_memory_wb_stb, main_memory_wb_wr_en,
        input  main_memory_wb_addr, main_memory_wb_wr_data, main_memory_wb_wr_sel,
        output main_memory_wb_ack, main_memory_wb_stall, main_memory_wb_rd_data
    );
endinterface

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port synchronous memory between the instruction-fetch
// port and the Wishbone data port. One transaction is in flight at a time:
// grant (IDLE) -> memory read latency (WAIT) -> acknowledge (RESP).
module mem_arbiter #(
    parameter int   MEMORY_DEPTH  = 1024,
    parameter bit   DATA_PRIORITY = 1'b0,
    localparam int  AW            = $clog2(MEMORY_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {PORT_INSTR, PORT_DATA} port_t;

    state_t      state;
    state_t      state_next;
    port_t       granted;
    port_t       last_grant;
    port_t       winner;
    logic        instr_pending;
    logic        data_pending;
    logic        grant_valid;
    logic        instr_ack_q;
    logic        wb_ack_q;
    logic [31:0] instr_q;
    logic [31:0] wb_rd_data_q;

    // Only the word-address bits select memory; the rest wrap silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.main_memory_instr_addr[31:AW+2], bus.main_memory_instr_addr[1:0],
                                bus.main_memory_wb_addr[31:AW+2],    bus.main_memory_wb_addr[1:0]};

    // Arbitration: pick the winning port among pending requests.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        instr_pending = bus.main_memory_instr_req;
        data_pending  = bus.main_memory_wb_cyc & bus.main_memory_wb_stb;
        winner        = PORT_INSTR;
        if (data_pending && !instr_pending) begin
            winner = PORT_DATA;
        end else if (data_pending && instr_pending) begin
            if (DATA_PRIORITY) begin
                winner = PORT_DATA;
            end else if (last_grant == PORT_INSTR) begin
                winner = PORT_DATA;
            end else begin
                winner = PORT_INSTR;
            end
        end
        // Reset gating keeps the memory quiet while rst is held low.
        grant_valid = (state == IDLE) && rst && (instr_pending || data_pending);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a grant always takes exactly three cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: memory strobe in the grant cycle, stall and acks to the core.
    always_comb begin
        mem_en    = grant_valid;
        mem_we    = (grant_valid && winner == PORT_DATA && bus.main_memory_wb_wr_en)
                    ? bus.main_memory_wb_wr_sel : 4'b0000;
        mem_addr  = (winner == PORT_DATA) ? bus.main_memory_wb_addr[AW+1:2]
                                          : bus.main_memory_instr_addr[AW+1:2];
        mem_wdata = bus.main_memory_wb_wr_data;

        bus.main_memory_wb_stall   = !(grant_valid && winner == PORT_DATA);
        bus.main_memory_instr_ack  = instr_ack_q;
        // Dropping cyc during RESP aborts the cycle, so the ack is suppressed live.
        bus.main_memory_wb_ack     = wb_ack_q & bus.main_memory_wb_cyc;
        bus.main_memory_instr      = instr_q;
        bus.main_memory_wb_rd_data = wb_rd_data_q;
    end

    // Grant bookkeeping, response capture and one-cycle ack generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            granted      <= PORT_DATA;
            last_grant   <= PORT_DATA;
            instr_ack_q  <= 1'b0;
            wb_ack_q     <= 1'b0;
            instr_q      <= '0;
            wb_rd_data_q <= '0;
        end else begin
            if (grant_valid) begin
                granted    <= winner;
                last_grant <= winner;
            end

            instr_ack_q <= (state == WAIT) && (granted == PORT_INSTR);
            // An abort during WAIT means the RESP cycle carries no ack.
            wb_ack_q    <= (state == WAIT) && (granted == PORT_DATA) && bus.main_memory_wb_cyc;

            if (state == WAIT && granted == PORT_INSTR) begin
                instr_q <= mem_rdata;
            end
            // Aborted reads leave the previously returned data untouched.
            if (state == WAIT && granted == PORT_DATA && bus.main_memory_wb_cyc) begin
                wb_rd_data_q <= mem_rdata;
            end
        end
    end

endmodule
